// File: rtl/vga_frame_streamer.sv
// Streams one frame buffer over Avalon-MM bursts into the downstream VGA FIFO, restarting each frame.
// Optional DOUBLE_BUFFER_EN: swap_req toggles between base0 and base1 at the next frame boundary.
module vga_frame_streamer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BURST_LEN   = 8,
    parameter int BUF_DEPTH   = 16,
    parameter int FRAME_WORDS = 307200
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        pll_locked,
    input  logic                        enable,
    input  logic [ADDR_W-1:0]           base0,
    input  logic [ADDR_W-1:0]           base1,
    input  logic                        swap_req,
    output logic [ADDR_W-1:0]           avm_address,
    output logic                        avm_read,
    output logic [$clog2(BURST_LEN):0]  avm_burstcount,
    input  logic                        avm_waitrequest,
    input  logic [DATA_W-1:0]           avm_readdata,
    input  logic                        avm_readdatavalid,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           exportdata,
    output logic                        frame_sel,
    output logic                        frame_done
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int REQ_W = $clog2(FRAME_WORDS + 1);
    localparam int BC_W  = $clog2(BURST_LEN) + 1;

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [REQ_W-1:0]  BURST_REQ   = REQ_W'(BURST_LEN);
    localparam logic [REQ_W-1:0]  FRAME_REQ   = REQ_W'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W-1:0]  outstanding;
    logic [REQ_W-1:0]  req_count;
    logic [CNT_W:0]    committed;
    logic              swap_pend;
    logic              run;
    logic              accept;
    logic              rdv_ours;
    logic              buf_wr;
    logic              room;
    logic              flush_done;
    logic              abort;
    logic              next_sel;
    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W-1:0] next_base;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign run        = pll_locked & enable;
    assign accept     = (state == ISSUE) & avm_read & ~avm_waitrequest;
    // Words arriving with nothing outstanding are leftovers from before a reset and are dropped.
    assign rdv_ours   = avm_readdatavalid & (outstanding != '0);
    assign buf_wr     = rdv_ours & (state != IDLE);
    assign committed  = {1'b0, buf_count} + {1'b0, outstanding} + {1'b0, BURST_CNT};
    assign room       = committed <= (CNT_W + 1)'(BUF_DEPTH);
    assign flush_done = (outstanding == '0) & (buf_count == '0);
    assign abort      = ~run & (state != IDLE) & ~((state == FLUSH) & flush_done);

    assign fifo_wr_en     = (buf_count != '0) & ~fifo_full;
    assign exportdata     = (buf_count != '0) ? buf_mem[rd_ptr] : '0;
    assign avm_burstcount = BC_W'(BURST_LEN);

    assign next_sel  = frame_sel ^ swap_pend;
    assign cur_base  = frame_sel ? base1 : base0;
    assign next_base = next_sel ? base1 : base0;

`ifdef DOUBLE_BUFFER_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            swap_pend <= 1'b0;
            frame_sel <= 1'b0;
        end else if ((state == FLUSH) && flush_done) begin
            frame_sel <= next_sel;
            swap_pend <= swap_req;
        end else if (swap_req) begin
            swap_pend <= 1'b1;
        end
    end
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign swap_pend       = 1'b0;
    assign frame_sel       = 1'b0;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= '0;
            req_count   <= '0;
            outstanding <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            outstanding <= outstanding + (accept ? BURST_CNT : '0) - (rdv_ours ? CNT_W'(1) : '0);
            case (state)
                IDLE: begin
                    // Aborted reads must fully drain before a new frame may start.
                    if (run && (outstanding == '0)) begin
                        state       <= ISSUE;
                        avm_read    <= 1'b1;
                        avm_address <= cur_base;
                        req_count   <= '0;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        avm_read    <= 1'b0;
                        avm_address <= avm_address + BURST_BYTES;
                        req_count   <= req_count + BURST_REQ;
                        if (!run) begin
                            state <= IDLE;
                        end else if (req_count + BURST_REQ >= FRAME_REQ) begin
                            state <= FLUSH;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (!run) begin
                        avm_read <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (room) begin
                        state    <= ISSUE;
                        avm_read <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        frame_done <= 1'b1;
                        if (run) begin
                            state       <= ISSUE;
                            avm_read    <= 1'b1;
                            avm_address <= next_base;
                            req_count   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!run) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || abort) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (buf_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_wr_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({buf_wr, fifo_wr_en})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (buf_wr) buf_mem[wr_ptr] <= avm_readdata;
    end

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Randomized bench for vga_frame_streamer: Avalon slave model plus a frame-order pixel reference.
module tb_vga_frame_streamer;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int BURST_LEN   = 8;
    localparam int BUF_DEPTH   = 16;
    localparam int FRAME_WORDS = 64;
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic              pll_locked;
    logic              enable;
    logic [ADDR_W-1:0] base0;
    logic [ADDR_W-1:0] base1;
    logic              swap_req;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] exportdata;
    logic              frame_sel;
    logic              frame_done;

    always #5 clk_clk = ~clk_clk;

    vga_frame_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
        .BUF_DEPTH(BUF_DEPTH), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .pll_locked(pll_locked), .enable(enable),
        .base0(base0), .base1(base1), .swap_req(swap_req),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .exportdata(exportdata), .frame_sel(frame_sel), .frame_done(frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Frame-buffer contents as seen by the slave: a fixed scramble of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    logic [31:0] rq[$];
    logic [31:0] b0, b1, prev_addr;
    bit exp_sel, pend, quiet, prev_stall;
    bit rand_wait, rand_rdv, rand_full, rdv_pause, wr_hold_arm;
    int exp_idx, burst_idx, occ, frames, delivered, stalls, wr_hold, full_hold;

    function automatic logic [31:0] cur_base();
        return exp_sel ? b1 : b0;
    endfunction

    task automatic step();
        @(negedge clk_clk);
        if (wr_hold_arm && avm_read) begin
            wr_hold     = 5;
            wr_hold_arm = 0;
        end
        if (wr_hold > 0) begin
            avm_waitrequest = 1'b1;
            wr_hold--;
        end else begin
            avm_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
        end
        if (!rdv_pause && rq.size() > 0 && (!rand_rdv || $urandom_range(0, 3) != 0)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem_word(rq.pop_front());
            delivered++;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
        if (full_hold > 0) begin
            fifo_full = 1'b1;
            full_hold--;
        end else begin
            fifo_full = rand_full && ($urandom_range(0, 4) == 0);
        end
        #1;
        if (prev_stall && !quiet) begin
            check("hold_read", avm_read, 1);
            check("hold_addr", avm_address, prev_addr);
            check("hold_bcnt", avm_burstcount, BURST_LEN);
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        if (prev_stall) stalls++;
        if (frame_done) begin
            check("done_words", exp_idx, FRAME_WORDS);
            check("done_bursts", burst_idx, FRAME_WORDS / BURST_LEN);
`ifdef DOUBLE_BUFFER_EN
            if (pend) begin
                exp_sel = ~exp_sel;
                pend    = 0;
            end
`endif
            check("frame_sel", frame_sel, exp_sel);
            frames++;
            exp_idx   = 0;
            burst_idx = 0;
            occ       = 0;
        end
        if (avm_read && !avm_waitrequest) begin
            check("burst_addr", avm_address, cur_base() + burst_idx * BURST_BYTES);
            check("burstcount", avm_burstcount, BURST_LEN);
            for (int i = 0; i < BURST_LEN; i++) rq.push_back(avm_address + i * 4);
            burst_idx++;
            occ += BURST_LEN;
        end
        if (fifo_full) check("wr_en_full", fifo_wr_en, 0);
        if (quiet) begin
            check("quiet_wr_en", fifo_wr_en, 0);
            check("quiet_read", avm_read, 0);
        end
        if (fifo_wr_en) begin
            check("pixel", exportdata, mem_word(cur_base() + exp_idx * 4));
            exp_idx++;
            occ--;
        end
        check("occupancy", occ <= BUF_DEPTH, 1);
    endtask

    task automatic run_frames(input int n, input int budget);
        int target = frames + n;
        int c = 0;
        while (frames < target && c < budget) begin
            step();
            c++;
        end
        check("frames_done", frames, target);
    endtask

    task automatic wait_word(input int target, input int budget);
        int c = 0;
        while (exp_idx < target && c < budget) begin
            step();
            c++;
        end
        check("reach_word", exp_idx >= target, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", exportdata, 0);
        check("rst_sel", frame_sel, 0);
        check("rst_done", frame_done, 0);
    endtask

    initial begin
        int c;
        b0 = $urandom & 32'h0FFF_FFC0;
        b1 = ($urandom & 32'h0FFF_FFC0) | 32'h4000_0000;
        base0 = b0; base1 = b1;
        reset_reset = 1'b1; pll_locked = 1'b0; enable = 1'b0; swap_req = 1'b0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; fifo_full = 1'b0;
        exp_sel = 0; pend = 0; quiet = 1; prev_stall = 0; prev_addr = '0;
        rand_wait = 0; rand_rdv = 0; rand_full = 0; rdv_pause = 0; wr_hold_arm = 0;
        exp_idx = 0; burst_idx = 0; occ = 0; frames = 0; delivered = 0; stalls = 0;
        wr_hold = 0; full_hold = 0;

        repeat (3) step();
        check_reset_outputs();
        reset_reset = 1'b0;
        step();

        // Free-running frames under random backpressure on both sides.
        quiet = 0; pll_locked = 1'b1; enable = 1'b1;
        rand_wait = 1; rand_rdv = 1; rand_full = 1;
        run_frames(2, 3000);

        // One burst held off by waitrequest for five cycles.
        rand_wait = 0; stalls = 0; wr_hold_arm = 1;
        run_frames(1, 2000);
        check("wait_hold_len", stalls, 5);

        // Downstream FIFO full for 200 cycles mid-frame.
        rand_wait = 1; rand_full = 0;
        wait_word(20, 500);
        full_hold = 200;
        run_frames(1, 3000);

        // PLL lock lost after 3 words of the second burst have returned.
        delivered = 0; c = 0;
        while (delivered < BURST_LEN + 3 && c < 500) begin
            step();
            c++;
        end
        check("abort_point", delivered, BURST_LEN + 3);
        rdv_pause = 1;
        step();
        pll_locked = 1'b0; quiet = 1;
        exp_idx = 0; burst_idx = 0; occ = 0;
        rdv_pause = 0;
        repeat (40) step();
        quiet = 0; pll_locked = 1'b1;
        run_frames(1, 2000);

        // Reset with two bursts outstanding; late read data must be ignored.
        rand_wait = 0; rdv_pause = 1; c = 0;
        while (occ < 2 * BURST_LEN && c < 100) begin
            step();
            c++;
        end
        check("two_outstanding", occ, 2 * BURST_LEN);
        reset_reset = 1'b1; enable = 1'b0; quiet = 1;
        exp_idx = 0; burst_idx = 0; occ = 0; exp_sel = 0; pend = 0;
        step();
        check_reset_outputs();
        reset_reset = 1'b0; rdv_pause = 0; rand_rdv = 0;
        repeat (30) step();
        rand_rdv = 1; quiet = 0; enable = 1'b1;
        run_frames(1, 2000);

        // Two swap requests inside one frame.
        wait_word(10, 500);
        swap_req = 1'b1; pend = 1;
        step();
        swap_req = 1'b0;
        wait_word(30, 500);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        run_frames(2, 4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
